systolic_seq: RTL

- Sequencer for an N×N systolic array of accumulate PEs (operands flow right/down, per-PE init restarts accumulation and emits the previous sum onto the row result chain).
- Accepts a job with inner dimension K and issues operand-memory reads.
- Generates the diagonal init wavefront, runs a flush wavefront to drain the final sums, and counts and tags the result stream per row.

---
 rtl/systolic_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/systolic_seq.sv
// Sequencer for an N x N systolic array of accumulate PEs: issues operand reads, drives the
// diagonal init/flush wavefronts and counts/tags the per-row result stream.
module systolic_seq #(
  parameter int unsigned N      = 4,
  parameter int unsigned K_W    = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [K_W-1:0] i_start_k,
  output logic           o_start_ready,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err,
  output logic           o_rd_en,
  output logic [K_W-1:0] o_rd_addr,
  output logic           o_zero_feed,
  output logic [2*N-2:0] o_init_diag,
  input  logic [N-1:0]   i_res_valid,
  output logic [N-1:0]   o_res_discard
);

  localparam int unsigned CntW = $clog2(2 * N + 1);
  localparam int unsigned PLen = RD_LAT + 2 * N - 2;
  localparam logic [CntW-1:0] CntFull = CntW'(2 * N);
  localparam logic [CntW-1:0] CntHalf = CntW'(N);

  typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDrain} state_e;

  state_e          r_state, w_state_next;
  logic [K_W-1:0]  r_k, r_idx;
  logic [PLen-1:0] r_pdly;
  logic [RD_LAT-1:0] r_zdly;
  logic [CntW-1:0] r_cnt [N];
  logic [CntW-1:0] w_cnt_next [N];
  logic            r_done, r_err;
  logic            w_busy, w_k_ok, w_accept, w_reject, w_last_k;
  logic            w_all_full, w_overrun, w_p, w_z;

  assign w_busy   = (r_state != StIdle);
  assign w_k_ok   = (i_start_k >= K_W'(N));
  assign w_accept = !w_busy && i_start && w_k_ok;
  assign w_reject = !w_busy && i_start && !w_k_ok;
  assign w_last_k = (r_idx == r_k - 1'b1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_next = StFeed;
      StFeed:  if (w_last_k) w_state_next = StFlush;
      StFlush: w_state_next = StDrain;
      StDrain: w_state_next = StDrain;
      default: w_state_next = StIdle;
    endcase
    if (w_busy && w_all_full) w_state_next = StIdle;
  end

  always_comb begin
    o_start_ready = !w_busy;
    o_busy        = w_busy;
    o_rd_en       = (r_state == StFeed);
    o_rd_addr     = r_idx;
    // p marks the first read of the feed and the flush cycle; both launch a wavefront.
    w_p           = (o_rd_en && (r_idx == '0)) || (r_state == StFlush);
    w_z           = (r_state == StFlush);
    o_done        = r_done;
    o_err         = r_err;
    o_zero_feed   = r_zdly[RD_LAT-1];
    o_init_diag   = r_pdly[PLen-1:RD_LAT-1];
  end

  always_comb begin
    w_overrun  = 1'b0;
    w_all_full = 1'b1;
    for (int r = 0; r < N; r++) begin
      w_cnt_next[r]    = r_cnt[r];
      o_res_discard[r] = i_res_valid[r] && (r_cnt[r] < CntHalf);
      if (w_busy && i_res_valid[r]) begin
        if (r_cnt[r] == CntFull) w_overrun = 1'b1;
        else w_cnt_next[r] = r_cnt[r] + 1'b1;
      end
      if (w_cnt_next[r] != CntFull) w_all_full = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k    <= '0;
      r_idx  <= '0;
      r_pdly <= '0;
      r_zdly <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      for (int r = 0; r < N; r++) r_cnt[r] <= '0;
    end else begin
      if (w_accept) r_k <= i_start_k;
      if (r_state == StFeed) r_idx <= w_last_k ? '0 : r_idx + 1'b1;
      r_pdly <= (r_pdly << 1) | PLen'(w_p);
      r_zdly <= (r_zdly << 1) | RD_LAT'(w_z);
      r_done <= w_busy && w_all_full;
      r_err  <= w_reject || w_overrun;
      for (int r = 0; r < N; r++) r_cnt[r] <= w_accept ? '0 : w_cnt_next[r];
    end
  end

endmodule
